axaddr_expander: RTL and testbench

Slave-side counterpart of the burst partitioner. It accepts AXI AW or AR address-channel requests and buffers them in a small FIFO. Each buffered burst is expanded into one word-aligned beat address per data transfer, with first/last/error flags, on a valid/ready beat interface. It sits between the AXI slave address channel and the memory or data-channel logic of a responder.

---
 rtl/axaddr_expander.sv | 187 ++++++++++++++++++
 tb/tb_axaddr_expander.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axaddr_expander.sv
// axaddr_expander: buffers AXI AW/AR address requests in a small FIFO and
// expands each burst into one word-aligned beat address per data transfer,
// with first/last/error flags, on a valid/ready beat interface.
//
// state | meaning
// IDLE  | no burst loaded, bt_valid low, waiting for a FIFO entry
// BUSY  | burst loaded, current beat presented on bt_*
module axaddr_expander #(
  parameter int AXI_DW     = 128,
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2,
  parameter int AMI_AD     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AXI_IW-1:0]     axid,
  input  logic [AXI_AW-1:0]     axaddr,
  input  logic [AXI_LW-1:0]     axlen,
  input  logic [AXI_SW-1:0]     axsize,
  input  logic [AXI_BURSTW-1:0] axburst,
  input  logic                  axvalid,
  output logic                  axready,
  output logic [AXI_IW-1:0]     bt_id,
  output logic [AXI_AW-1:0]     bt_addr,
  output logic                  bt_first,
  output logic                  bt_last,
  output logic                  bt_err,
  output logic                  bt_valid,
  input  logic                  bt_ready
);
  localparam int AXI_BYTES = AXI_DW / 8;
  localparam int L         = $clog2(AXI_BYTES);
  localparam int PW        = $clog2(AMI_AD);

  localparam logic [AXI_BURSTW-1:0] BURST_FIXED = AXI_BURSTW'(0);
  localparam logic [AXI_BURSTW-1:0] BURST_INCR  = AXI_BURSTW'(1);
  localparam logic [AXI_BURSTW-1:0] BURST_WRAP  = AXI_BURSTW'(2);
  localparam logic [AXI_BURSTW-1:0] BURST_RSVD  = AXI_BURSTW'(3);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state, state_nxt;

  // Request FIFO; only the word-aligned part of the address is stored
  logic [AXI_IW-1:0]     fifo_id    [AMI_AD];
  logic [AXI_AW-1:L]     fifo_addr  [AMI_AD];
  logic [AXI_LW-1:0]     fifo_len   [AMI_AD];
  logic [AXI_SW-1:0]     fifo_size  [AMI_AD];
  logic [AXI_BURSTW-1:0] fifo_burst [AMI_AD];
  logic [PW:0]           wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty, push, pop;

  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^axaddr[L-1:0];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign axready    = !fifo_full;
  assign push       = axvalid && !fifo_full;

  // FIFO storage, written on push only
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_ptr[PW-1:0]]    <= axid;
      fifo_addr[wr_ptr[PW-1:0]]  <= axaddr[AXI_AW-1:L];
      fifo_len[wr_ptr[PW-1:0]]   <= axlen;
      fifo_size[wr_ptr[PW-1:0]]  <= axsize;
      fifo_burst[wr_ptr[PW-1:0]] <= axburst;
    end
  end

  // FIFO pointers; push and pop are independent so a simultaneous pair keeps the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [AXI_IW-1:0]     head_id;
  logic [AXI_AW-1:L]     head_addr;
  logic [AXI_LW-1:0]     head_len;
  logic [AXI_SW-1:0]     head_size;
  logic [AXI_BURSTW-1:0] head_burst;
  logic                  head_wrap_ok, head_err;

  assign head_id    = fifo_id[rd_ptr[PW-1:0]];
  assign head_addr  = fifo_addr[rd_ptr[PW-1:0]];
  assign head_len   = fifo_len[rd_ptr[PW-1:0]];
  assign head_size  = fifo_size[rd_ptr[PW-1:0]];
  assign head_burst = fifo_burst[rd_ptr[PW-1:0]];

  assign head_wrap_ok = (head_len == AXI_LW'(1)) || (head_len == AXI_LW'(3)) ||
                        (head_len == AXI_LW'(7)) || (head_len == AXI_LW'(15));
  assign head_err     = (head_size != AXI_SW'(L)) || (head_burst == BURST_RSVD) ||
                        ((head_burst == BURST_WRAP) && !head_wrap_ok);

  // Current burst context; an erroring burst is walked as FIXED
  logic [AXI_LW-1:0]     cnt, cnt_inc, cur_len;
  logic [AXI_BURSTW-1:0] cur_mode;
  logic                  last_beat, load, advance;
  logic [AXI_AW-1:0]     addr_inc, wrap_mask, addr_nxt;

  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = (cnt == cur_len);
  assign addr_inc  = bt_addr + AXI_AW'(AXI_BYTES);
  assign wrap_mask = (AXI_AW'(cur_len) << L) | AXI_AW'(AXI_BYTES - 1);

  // Next beat address according to the burst mode
  always_comb begin
    addr_nxt = bt_addr;
    case (cur_mode)
      BURST_INCR: addr_nxt = addr_inc;
      BURST_WRAP: addr_nxt = (bt_addr & ~wrap_mask) | (addr_inc & wrap_mask);
      default:    addr_nxt = bt_addr;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = BUSY;
      BUSY:    if (bt_ready && last_beat && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes: load pops the FIFO head, advance steps within a burst
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: load = !fifo_empty;
      BUSY: begin
        if (bt_ready) begin
          if (last_beat) load = !fifo_empty;
          else           advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pop      = load;
  assign bt_valid = (state == BUSY);

  // Beat registers: loaded from the FIFO head or stepped on an accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bt_id    <= '0;
      bt_addr  <= '0;
      bt_first <= 1'b0;
      bt_last  <= 1'b0;
      bt_err   <= 1'b0;
      cnt      <= '0;
      cur_len  <= '0;
      cur_mode <= BURST_FIXED;
    end else if (load) begin
      bt_id    <= head_id;
      bt_addr  <= {head_addr, {L{1'b0}}};
      bt_first <= 1'b1;
      bt_last  <= (head_len == '0);
      bt_err   <= head_err;
      cnt      <= '0;
      cur_len  <= head_len;
      cur_mode <= head_err ? BURST_FIXED : head_burst;
    end else if (advance) begin
      bt_addr  <= addr_nxt;
      bt_first <= 1'b0;
      bt_last  <= (cnt_inc == cur_len);
      cnt      <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_axaddr_expander.sv
// Testbench for axaddr_expander: directed scenarios plus randomized traffic
// checked against a behavioural beat model.
module tb_axaddr_expander;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int LW = 8;
  localparam int SW = 3;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] axid;
  logic [AW-1:0] axaddr;
  logic [LW-1:0] axlen;
  logic [SW-1:0] axsize;
  logic [BW-1:0] axburst;
  logic          axvalid;
  logic          axready;
  logic [IW-1:0] bt_id;
  logic [AW-1:0] bt_addr;
  logic          bt_first, bt_last, bt_err, bt_valid, bt_ready;
  logic          man_ready, rand_ready, rand_bit;

  assign bt_ready = rand_ready ? rand_bit : man_ready;

  axaddr_expander #(
    .AXI_DW(128), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
    .AXI_SW(SW), .AXI_BURSTW(BW), .AMI_AD(4)
  ) dut (
    .clk(clk), .reset(reset),
    .axid(axid), .axaddr(axaddr), .axlen(axlen), .axsize(axsize),
    .axburst(axburst), .axvalid(axvalid), .axready(axready),
    .bt_id(bt_id), .bt_addr(bt_addr), .bt_first(bt_first), .bt_last(bt_last),
    .bt_err(bt_err), .bt_valid(bt_valid), .bt_ready(bt_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  beat_t seen_q[$];
  beat_t e, held;
  logic  stall_q = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: expected beats of one accepted request, from plain address arithmetic
  function automatic void model_push(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                     input logic [LW-1:0] len, input logic [SW-1:0] size,
                                     input logic [BW-1:0] burst);
    longint unsigned a0, w, base, a;
    bit err;
    beat_t b;
    a0   = addr;
    a0   = a0 - (a0 % 16);
    err  = (size != 3'd4) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    w    = (longint'(len) + 1) * 16;
    base = a0 - (a0 % w);
    for (int i = 0; i <= int'(len); i++) begin
      if (err || burst == 2'd0)  a = a0;
      else if (burst == 2'd1)    a = (a0 + longint'(i) * 16) % (64'd1 << 32);
      else                       a = base + ((a0 - base + longint'(i) * 16) % w);
      b.id    = id;
      b.addr  = a[31:0];
      b.first = (i == 0);
      b.last  = (i == int'(len));
      b.err   = err;
      exp_q.push_back(b);
    end
  endfunction

  // Monitor: sample at negedge, i.e. the values the next rising edge acts on
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (axvalid && axready) model_push(axid, axaddr, axlen, axsize, axburst);
      if (stall_q) begin
        chk("stall_valid", bt_valid, 1);
        chk("stall_addr", bt_addr, held.addr);
        chk("stall_id", bt_id, held.id);
        chk("stall_flags", {bt_first, bt_last, bt_err}, {held.first, held.last, held.err});
      end
      if (bt_valid && bt_ready) begin
        e.id = bt_id; e.addr = bt_addr; e.first = bt_first; e.last = bt_last; e.err = bt_err;
        seen_q.push_back(e);
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", bt_addr, e.addr);
          chk("beat_id", bt_id, e.id);
          chk("beat_first", bt_first, e.first);
          chk("beat_last", bt_last, e.last);
          chk("beat_err", bt_err, e.err);
        end
      end
      stall_q    = bt_valid && !bt_ready;
      held.id    = bt_id;
      held.addr  = bt_addr;
      held.first = bt_first;
      held.last  = bt_last;
      held.err   = bt_err;
    end
  end

  // All tasks start and end just after a rising edge
  task automatic send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                      input logic [SW-1:0] size, input logic [BW-1:0] burst);
    bit ok;
    ok = 0;
    axid = id; axaddr = addr; axlen = len; axsize = size; axburst = burst; axvalid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (axready) begin
        ok = 1;
        break;
      end
    end
    chk("req_accept", ok, 1);
    @(posedge clk); #1;
    axvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bt_valid) begin
        done = 1;
        break;
      end
    end
    chk(tag, done, 1);
    @(posedge clk); #1;
  endtask

  task automatic seen_at(input string tag, input int idx, input logic [AW-1:0] addr,
                         input logic first, input logic last, input logic err);
    if (idx < seen_q.size()) begin
      chk({tag, "_addr"}, seen_q[idx].addr, addr);
      chk({tag, "_flags"}, {seen_q[idx].first, seen_q[idx].last, seen_q[idx].err}, {first, last, err});
    end else begin
      chk({tag, "_missing"}, seen_q.size(), idx + 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_v;
    logic [LW-1:0] rl;
    reset = 1'b0; axvalid = 1'b0; axid = '0; axaddr = '0; axlen = '0; axsize = '0; axburst = '0;
    man_ready = 1'b0; rand_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bt_valid, 0);
    chk("rst_addr", bt_addr, 0);
    chk("rst_id", bt_id, 0);
    chk("rst_flags", {bt_first, bt_last, bt_err}, 3'b000);
    chk("rst_axready", axready, 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // INCR with latency
    man_ready = 1'b1;
    seen_q.delete();
    send(8'h11, 32'h1000, 8'd3, 3'd4, 2'd1);
    @(negedge clk); chk("lat_n1_valid", bt_valid, 0);
    @(negedge clk); chk("lat_n2_valid", bt_valid, 1);
    drain("t1_drain");
    chk("t1_count", seen_q.size(), 4);
    seen_at("t1_b0", 0, 32'h1000, 1, 0, 0);
    seen_at("t1_b1", 1, 32'h1010, 0, 0, 0);
    seen_at("t1_b2", 2, 32'h1020, 0, 0, 0);
    seen_at("t1_b3", 3, 32'h1030, 0, 1, 0);

    // WRAP and INCR across the top of the address space
    seen_q.delete();
    send(8'h22, 32'h1038, 8'd3, 3'd4, 2'd2);
    send(8'h23, 32'hFFFF_FFF0, 8'd1, 3'd4, 2'd1);
    drain("t2_drain");
    chk("t2_count", seen_q.size(), 6);
    seen_at("t2_w0", 0, 32'h1030, 1, 0, 0);
    seen_at("t2_w1", 1, 32'h1000, 0, 0, 0);
    seen_at("t2_w2", 2, 32'h1010, 0, 0, 0);
    seen_at("t2_w3", 3, 32'h1020, 0, 1, 0);
    seen_at("t2_i0", 4, 32'hFFFF_FFF0, 1, 0, 0);
    seen_at("t2_i1", 5, 32'h0000_0000, 0, 1, 0);

    // FIXED
    seen_q.delete();
    send(8'h5A, 32'h2004, 8'd2, 3'd4, 2'd0);
    drain("t3_drain");
    chk("t3_count", seen_q.size(), 3);
    seen_at("t3_b0", 0, 32'h2000, 1, 0, 0);
    seen_at("t3_b1", 1, 32'h2000, 0, 0, 0);
    seen_at("t3_b2", 2, 32'h2000, 0, 1, 0);
    for (int i = 0; i < seen_q.size(); i++) chk("t3_id", seen_q[i].id, 8'h5A);

    // FIFO full, then back-to-back single beats
    man_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 32'(32'h5000 + i * 64), 8'd0, 3'd4, 2'd1);
    @(negedge clk); chk("full_axready", axready, 0);
    @(posedge clk); #1;
    man_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b2b_valid", bt_valid, 1);
      chk("b2b_first_last", {bt_first, bt_last}, 2'b11);
    end
    @(negedge clk); chk("b2b_idle", bt_valid, 0);
    @(posedge clk); #1;
    drain("t4_drain");

    // Error bursts followed by a good one
    seen_q.delete();
    send(8'h71, 32'h3044, 8'd3, 3'd2, 2'd1);
    send(8'h72, 32'h3100, 8'd1, 3'd4, 2'd3);
    send(8'h73, 32'h3208, 8'd2, 3'd4, 2'd2);
    send(8'h74, 32'h3300, 8'd1, 3'd4, 2'd1);
    drain("t5_drain");
    chk("t5_count", seen_q.size(), 11);
    for (int i = 0; i < 4; i++) seen_at("t5_size", i, 32'h3040, i == 0, i == 3, 1);
    for (int i = 0; i < 2; i++) seen_at("t5_rsvd", 4 + i, 32'h3100, i == 0, i == 1, 1);
    for (int i = 0; i < 3; i++) seen_at("t5_wrap", 6 + i, 32'h3200, i == 0, i == 2, 1);
    seen_at("t5_ok0", 9, 32'h3300, 1, 0, 0);
    seen_at("t5_ok1", 10, 32'h3310, 0, 1, 0);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       rl = 8'($urandom_range(0, 15));
        1:       rl = 8'd0;
        default: rl = 8'((1 << $urandom_range(1, 4)) - 1);
      endcase
      send(8'($urandom), 32'($urandom), rl,
           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd4,
           2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain("rand_drain");
    rand_ready = 1'b0;

    // Reset during beat 2 of an INCR burst with two requests queued
    man_ready = 1'b0;
    send(8'h61, 32'h4000, 8'd7, 3'd4, 2'd1);
    send(8'h62, 32'h4400, 8'd0, 3'd4, 2'd1);
    send(8'h63, 32'h4800, 8'd0, 3'd4, 2'd1);
    @(posedge clk); #1;
    man_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", bt_valid, 1);
    chk("pre_rst_addr", bt_addr, 32'h4020);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bt_valid, 0);
    chk("mid_rst_axready", axready, 1);
    chk("mid_rst_addr", bt_addr, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt_v = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bt_valid) cnt_v++;
    end
    chk("post_rst_beats", cnt_v, 0);
    chk("post_rst_axready", axready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
